text_write_queue: RTL and testbench

TEXT_WRITE_QUEUE -- requirements
Module: text_write_queue

---
 rtl/text_write_queue.sv | 118 +++++++++++
 tb/tb_text_write_queue.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/text_write_queue.sv
// Circular queue of {row,col,char} writes feeding a VGA text controller one
// character at a time, with sticky overflow and done-timeout flags.
module text_write_queue #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     in_valid,
    input  logic [7:0]               in_row,
    input  logic [7:0]               in_col,
    input  logic [7:0]               in_char,
    output logic                     in_ready,
    output logic [7:0]               out_row,
    output logic [7:0]               out_col,
    output logic [7:0]               out_char,
    output logic                     out_start,
    input  logic                     out_done,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     timeout_err,
    output logic [1:0]               dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL    = (AW + 1)'(DEPTH);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t         state;
    logic [23:0]    mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [15:0]    wait_cnt;
    logic           push;
    logic           pop;

    // Handshake: an entry is taken on every rising edge where in_valid and
    // in_ready are both high; in_valid while full is dropped and sets overflow.
    // out_start pulses once per write, out_done is honoured only in WAIT_DONE.
    assign in_ready  = (count < FULL);
    assign push      = in_valid && in_ready;
    assign pop       = (state == IDLE) && (count != '0);
    assign dbg_state = state;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {in_row, in_col, in_char};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            rd_ptr      <= '0;
            wait_cnt    <= '0;
            out_start   <= 1'b0;
            out_row     <= '0;
            out_col     <= '0;
            out_char    <= '0;
            timeout_err <= 1'b0;
        end else begin
            out_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        {out_row, out_col, out_char} <= mem[rd_ptr];
                        rd_ptr <= rd_ptr + 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    out_start <= 1'b1;
                    wait_cnt  <= '0;
                    state     <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (out_done) begin
                        state <= IDLE;
                    end else if (wait_cnt == TO_LAST) begin
                        // Controller never answered: drop this write and move on.
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_text_write_queue.sv
// Bench for text_write_queue: directed scenarios plus random traffic checked
// every cycle against an edge-numbered transaction model and an order queue.
module tb_text_write_queue;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_row = '0, in_col = '0, in_char = '0;
    logic          out_done = 1'b0;
    logic          in_ready, out_start, overflow, timeout_err;
    logic [7:0]    out_row, out_col, out_char;
    logic [CW-1:0] count;
    logic [1:0]    dbg_state;

    text_write_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .resetn(resetn), .in_valid(in_valid),
        .in_row(in_row), .in_col(in_col), .in_char(in_char),
        .in_ready(in_ready), .out_row(out_row), .out_col(out_col),
        .out_char(out_char), .out_start(out_start), .out_done(out_done),
        .count(count), .overflow(overflow), .timeout_err(timeout_err),
        .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    // Reference model: pending entries, the in-flight entry and the edge it was loaded on.
    logic [23:0] pend[$];
    logic [23:0] exp_q[$];
    logic [23:0] cur;
    bit          busy, m_ov, m_te;
    int          n, load_edge;
    int          done_mode, done_lat;
    int          n_tests, n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        exp_q.delete();
        cur  = '0;
        busy = 0;
        m_ov = 0;
        m_te = 0;
    endtask

    task automatic model_edge();
        int cnt0;
        cnt0 = pend.size();
        if (!resetn) begin
            model_reset();
            return;
        end
        if (busy && n >= load_edge + 2) begin
            if (out_done) busy = 0;
            else if (n == load_edge + 1 + TIMEOUT) begin
                m_te = 1;
                busy = 0;
            end
        end else if (!busy && cnt0 > 0) begin
            cur       = pend.pop_front();
            busy      = 1;
            load_edge = n;
        end
        if (in_valid) begin
            if (cnt0 < DEPTH) begin
                pend.push_back({in_row, in_col, in_char});
                exp_q.push_back({in_row, in_col, in_char});
            end else begin
                m_ov = 1;
            end
        end
    endtask

    task automatic check_outputs();
        int exp_state;
        exp_state = !busy ? 0 : (n == load_edge) ? 1 : 2;
        check_eq("count", 32'(count), 32'(pend.size()));
        check_eq("in_ready", 32'(in_ready), 32'(pend.size() < DEPTH));
        check_eq("out_start", 32'(out_start), 32'(busy && n == load_edge + 1));
        check_eq("out_entry", {8'h0, out_row, out_col, out_char}, {8'h0, cur});
        check_eq("overflow", 32'(overflow), 32'(m_ov));
        check_eq("timeout_err", 32'(timeout_err), 32'(m_te));
        check_eq("state", 32'(dbg_state), 32'(exp_state));
        if (out_start === 1'b1) begin
            if (exp_q.size() > 0) check_eq("order", {8'h0, out_row, out_col, out_char}, {8'h0, exp_q.pop_front()});
            else check_eq("order_empty", 32'(exp_q.size()), 32'd1);
        end
    endtask

    task automatic cycle(input bit v, input logic [23:0] e, input bit rn);
        @(negedge clock);
        check_outputs();
        in_valid = v;
        {in_row, in_col, in_char} = e;
        case (done_mode)
            0:       out_done = 1'b0;
            1:       out_done = ($urandom_range(0, 3) == 0);
            2:       out_done = busy && (n + 1 == load_edge + 2 + done_lat);
            default: out_done = 1'b1;
        endcase
        if (!rn) model_reset();
        resetn = rn;
        @(posedge clock);
        n++;
        model_edge();
    endtask

    task automatic rand_cycles(input int cycles, input int p_valid);
        for (int i = 0; i < cycles; i++)
            cycle($urandom_range(0, 99) < p_valid, 24'($urandom), 1'b1);
    endtask

    initial begin
        int pushes;
        n_tests = 0; n_fail = 0; n = 0; load_edge = 0;
        done_mode = 0; done_lat = 0;
        model_reset();
        cycle(0, '0, 0);
        cycle(0, '0, 0);
        cycle(0, '0, 1);

        // Single write, done three cycles after the start pulse.
        done_mode = 2; done_lat = 3;
        cycle(1, 24'h010141, 1);
        rand_cycles(12, 0);

        // Fill past full with done held low, then drain with short done latency.
        done_mode = 0;
        for (int i = 0; i < 10; i++) cycle(1, 24'h100000 + 24'(i), 1'b1);
        rand_cycles(3, 0);
        done_mode = 2; done_lat = 1;
        rand_cycles(60, 0);

        // Twenty pushes with immediate done: pointers wrap twice.
        done_mode = 2; done_lat = 0;
        pushes = 0;
        for (int i = 0; i < 200 && pushes < 20; i++) begin
            if ($urandom_range(0, 99) < 40) begin
                cycle(1, 24'($urandom), 1'b1);
                pushes++;
            end else begin
                cycle(0, '0, 1'b1);
            end
        end
        rand_cycles(40, 0);

        // Timeout: two entries, done never comes.
        cycle(0, '0, 0);
        done_mode = 0;
        cycle(1, 24'h0a0b41, 1);
        cycle(1, 24'h0a0c42, 1);
        rand_cycles(50, 0);

        // Reset in WAIT_DONE with three queued, then a late done.
        cycle(0, '0, 0);
        cycle(0, '0, 1);
        for (int i = 0; i < 4; i++) cycle(1, 24'h200000 + 24'(i), 1'b1);
        rand_cycles(3, 0);
        cycle(0, '0, 0);
        cycle(0, '0, 0);
        done_mode = 3;
        rand_cycles(10, 0);

        // Random traffic with occasional resets.
        done_mode = 1;
        for (int i = 0; i < 1500; i++)
            cycle($urandom_range(0, 99) < 50, 24'($urandom), $urandom_range(0, 299) != 0);
        done_mode = 0;
        rand_cycles(200, 70);
        done_mode = 2; done_lat = 2;
        rand_cycles(150, 0);
        check_eq("drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
